// File: rtl/instr_fetch_if.sv
// Fetch-side bus bundle: instruction memory port, redirect input and the
// valid/ready instruction stream toward decode.
interface instr_fetch_if #(
  parameter int S  = 32,
  parameter int AW = 8
);
  logic [AW-1:0] imem_a;
  logic [S-1:0]  imem_d;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          out_valid;
  logic [S-1:0]  out_instr;
  logic [AW-1:0] out_pc;
  logic          out_ready;

  modport master (
    output imem_a,
    input  imem_d,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    output out_instr,
    output out_pc,
    input  out_ready
  );

  modport slave (
    input  imem_a,
    output imem_d,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    input  out_instr,
    input  out_pc,
    output out_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: PC register drives an asynchronous word-addressed memory,
// returned words are queued with their PC in a 2-entry buffer toward decode.
module instr_fetch #(
  parameter int S        = 32,
  parameter int L        = 256,
  parameter int RESET_PC = 0
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master bus
);
  localparam int AW = $clog2(L);

  logic [AW-1:0] pc_q, pc_d;
  logic [1:0]    count_q, count_d;
  logic [S-1:0]  instr_q [2];
  logic [S-1:0]  instr_d [2];
  logic [AW-1:0] epc_q [2];
  logic [AW-1:0] epc_d [2];
  logic          pop;
  logic          push;

  always_comb begin
    pc_d    = pc_q;
    count_d = count_q;
    instr_d = instr_q;
    epc_d   = epc_q;
    pop     = (count_q != 2'd0) && bus.out_ready;
    push    = ((count_q != 2'd2) || pop) && !bus.redirect_valid;

    if (bus.redirect_valid) begin
      count_d = 2'd0;
      pc_d    = bus.redirect_pc;
    end else begin
      // Entry 0 is always the head; a pop shifts entry 1 down before any push lands.
      if (pop) begin
        instr_d[0] = instr_q[1];
        epc_d[0]   = epc_q[1];
        count_d    = count_q - 2'd1;
      end
      if (push) begin
        if (count_d == 2'd0) begin
          instr_d[0] = bus.imem_d;
          epc_d[0]   = pc_q;
        end else begin
          instr_d[1] = bus.imem_d;
          epc_d[1]   = pc_q;
        end
        count_d = count_d + 2'd1;
        pc_d    = pc_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= AW'(RESET_PC);
      count_q <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        instr_q[i] <= '0;
        epc_q[i]   <= '0;
      end
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      instr_q <= instr_d;
      epc_q   <= epc_d;
    end
  end

  assign bus.imem_a    = pc_q;
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_instr = bus.out_valid ? instr_q[0] : '0;
  assign bus.out_pc    = bus.out_valid ? epc_q[0] : '0;
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch-side initiator for the word-addressed asynchronous instruction memory (S-bit words, L locations, combinational read).
- Holds the program counter, drives the memory address, and captures each returned word with its PC into a 2-entry fetch buffer.
- Presents the instructions to the decode stage over a valid/ready handshake.
- Accepts branch/jump redirects, which flush the buffer.

Parameters:
- S, 32, instruction word width in bits
- L, 256, number of instruction memory locations; address width AW = $clog2(L)
- RESET_PC, 0, word address fetched first after reset (must be < L)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- imem_a  output  AW  word address to instruction memory; always equals the pc register (combinational)
- imem_d  input  S  read data from instruction memory; valid in the same cycle as imem_a
- redirect_valid  input  1  load a new PC this cycle and flush the buffer
- redirect_pc  input  AW  new word address, used when redirect_valid=1
- out_valid  output  1  buffer head holds a valid instruction
- out_instr  output  S  instruction at buffer head
- out_pc  output  AW  word address of out_instr
- out_ready  input  1  decode accepts the head this cycle

Behaviour:
- Addressing is in words: pc+1 is the next word, not the next byte. The increment wraps from L-1 to 0, computed modulo 2^AW; L is a power of two.
- Reset (rst=1 at a clk edge):
  - pc <= RESET_PC; buffer count <= 0.
  - out_valid=0 in the cycle after reset. out_instr and out_pc read 0 while the buffer is empty.
  - Reset overrides any redirect or handshake in the same cycle.
- Buffer: 2-entry FIFO of {instr, pc}, with count in 0..2.
  - pop = out_valid & out_ready.
  - push is allowed when (count<2 or pop) and redirect_valid=0.
  - On push: the entry stores {imem_d, pc}, and pc <= pc+1.
  - With no push, pc holds.
- Throughput: 1 instruction per cycle while out_ready=1.
- Latency: the word at address P appears on out_instr 1 cycle after pc=P, assuming it was pushed that cycle.
- First out_valid after reset: the cycle after rst deasserts. out_pc=RESET_PC and out_instr=mem[RESET_PC].
- Full with no pop (count=2, out_ready=0): no push, pc stable, imem_a stable, and the head outputs hold unchanged.
- Full with pop: pop and push happen in the same cycle, and count stays 2.
- Empty with push: count goes to 1. The new entry becomes head in the next cycle, never combinationally in the same cycle.
- Redirect (redirect_valid=1):
  - A pop in the same cycle still counts as consumed.
  - All entries are then discarded: count <= 0. No push occurs, and pc <= redirect_pc.
  - Next cycle: out_valid=0 and imem_a=redirect_pc.
  - The following cycle: out_valid=1 with out_pc=redirect_pc.
  - Redirect penalty: 1 bubble.
- Back-to-back redirects: the last one wins. Each flushes, and no instruction from an intermediate target is ever presented.
- A redirect while rst=1 is ignored.
- out_instr and out_pc must not change while out_valid=1 and out_ready=0. Only a redirect or a reset may drop an unaccepted head.

Test Plan:
- Memory words i -> 32'h1000_0000+i, RESET_PC=0, out_ready=1 continuously, reset released at cycle 0:
  - Cycle 1: out_valid=1, out_pc=0, out_instr=32'h1000_0000.
  - Cycles 2..5: out_pc 1..4 on consecutive cycles, no gaps.
- Backpressure, out_ready=0 for 4 cycles starting at out_pc=3:
  - out_pc=3 and out_instr=32'h1000_0003 held for all 4 cycles; count reaches 2; imem_a frozen at 5.
  - After out_ready returns to 1: out_pc 3,4,5,6 on consecutive cycles.
- Redirect to 8'hF0 pulsed while out_pc=2 is being accepted:
  - Next cycle: out_valid=0.
  - Following cycles: out_pc F0, F1, F2 with instr 32'h1000_00F0...
  - pc 3 is never presented.
- Wrap: redirect to 8'hFE with out_ready=1 -> out_pc sequence FE, FF, 00, 01 with matching instructions.
- Reset mid-stream: rst=1 for 1 cycle while count=2 and redirect_valid=1 (target 8'h40):
  - Next cycle: out_valid=0, redirect ignored.
  - The cycle after: out_pc=RESET_PC.
- Redirect on two consecutive cycles (targets 8'h20 then 8'h30) -> first valid output after them is out_pc=30; nothing at 20 or 21 is ever valid.
